change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Refund side of the vending datapath: takes a credit balance owed to the customer and pays it out as physical coins, one at a time, to the coin-return mechanism. It uses the same 2-bit coin code as the coin-acceptor FSM, in the opposite direction (machine -> customer). Payment is greedy, largest coin first, limited by per-denomination stock counters. It reports a shortfall when stock cannot cover the balance, and a jam when the mechanism stops acknowledging.

Parameters:
CREDIT_W, 4, width of refund amount and remaining balance
STOCK_W, 4, width of each per-denomination stock counter
TIMEOUT, 15, cycles PRESENT may wait for coin_ack before declaring jam (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
refund_req  input  1  start refund; sampled only in IDLE
refund_amt  input  CREDIT_W  credits owed; latched with refund_req
stock_load  input  1  load stock counters; sampled only in IDLE
stock1_in  input  STOCK_W  count of 1-credit coins (code 2'b01)
stock2_in  input  STOCK_W  count of 2-credit coins (code 2'b10)
stock5_in  input  STOCK_W  count of 5-credit coins (code 2'b11)
coin_ack  input  1  mechanism has released the presented coin
coin_out  output  2  coin code being presented; 2'b00 when not valid
coin_valid  output  1  coin_out is a live dispense request
busy  output  1  refund in progress (any state other than IDLE)
done  output  1  one-cycle pulse at end of a refund
shortfall  output  1  last refund could not be fully paid
short_amt  output  CREDIT_W  unpaid balance of last refund
jam  output  1  sticky mechanism-fault flag

Behaviour:
- Reset (synchronous, active-high) takes effect at the next clock edge. State goes to IDLE. All outputs go to 0. Stock counters, remaining balance and timeout counter go to 0. Reset overrides every other input, including mid-PRESENT.
- Coin values are fixed: 2'b01=1, 2'b10=2, 2'b11=5. Code 2'b00 means no coin.
- States: IDLE, SELECT, PRESENT, DONE, JAM.
- IDLE:
  - stock_load=1 loads all three counters from the *_in ports.
  - refund_req=1 latches remaining<=refund_amt and clears shortfall and short_amt.
  - If refund_amt==0 the next state is DONE; otherwise it is SELECT.
  - If stock_load and refund_req arrive in the same cycle, both take effect. SELECT then sees the newly loaded stock.
  - stock_load and refund_req are ignored in every other state.
- SELECT (one cycle, coin_valid=0):
  - Pick the largest denomination whose value <= remaining and whose stock > 0. Register its code and go to PRESENT.
  - If no denomination qualifies: set shortfall=1, short_amt=remaining, go to DONE.
- PRESENT:
  - coin_valid=1 with coin_out held stable.
  - If coin_ack=1: decrement remaining by the coin value and decrement the selected stock by 1. Go to DONE if the new remaining==0, else go to SELECT.
  - coin_ack while coin_valid=0 is ignored.
  - The timeout counter clears on entry to PRESENT and increments on each cycle without ack. When it reaches TIMEOUT without an ack, go to JAM.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 during DONE.
- JAM: jam=1, busy=1, coin_valid=0. All inputs except reset are ignored; only reset exits JAM.
- Latency:
  - refund_req at cycle 0 gives SELECT at cycle 1 and the first coin_valid at cycle 2.
  - After an ack at cycle n, the next coin_valid is at n+2; coin_valid is low at n+1.
  - After the final ack at cycle n, done=1 at n+1.
  - A zero-amount refund gives done=1 at cycle 1.
- Arithmetic: remaining never underflows, because SELECT only picks value <= remaining. Stock never underflows, because SELECT requires stock > 0.
- shortfall and short_amt hold their values until the next accepted refund_req or reset.

Test Plan:
1. Stock 5/5/5, refund 8, ack 1 cycle after each coin_valid -> coin_out sequence 11,10,01; done pulse; shortfall=0; stocks become 4/4/4.
2. Stock5=0, stock2=1, stock1=2, refund 4 -> coins 10,01,01; shortfall=0; stock2=0, stock1=0.
3. Stock1=1, others 0, refund 3 -> coin 01, then done with shortfall=1 and short_amt=2; a new refund_req clears both.
4. refund_amt=0 -> done=1 at cycle 1, no coin_valid at any point, busy high for exactly 1 cycle.
5. Refund 5 with coin_ack never asserted, TIMEOUT=15 -> after 15 PRESENT cycles jam=1 and coin_valid=0; later refund_req and stock_load are ignored; reset clears jam.
6. Reset asserted during PRESENT with coin_valid=1 -> next cycle all outputs 0 and state IDLE; a subsequent refund of 1 gives immediate shortfall=1 and short_amt=1, because stock was cleared by reset.

Source files
------------

// File: rtl/change_dispenser.sv
// Refund coin dispenser: pays a credit balance out greedily (5, 2, then 1) from
// per-denomination stock, flagging shortfall when stock runs out and jam on ack timeout.
module change_dispenser #(
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned STOCK_W  = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                refund_req,
    input  logic [CREDIT_W-1:0] refund_amt,
    input  logic                stock_load,
    input  logic [STOCK_W-1:0]  stock1_in,
    input  logic [STOCK_W-1:0]  stock2_in,
    input  logic [STOCK_W-1:0]  stock5_in,
    input  logic                coin_ack,
    output logic [1:0]          coin_out,
    output logic                coin_valid,
    output logic                busy,
    output logic                done,
    output logic                shortfall,
    output logic [CREDIT_W-1:0] short_amt,
    output logic                jam
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CoinNone = 2'b00;
    localparam logic [1:0] Coin1    = 2'b01;
    localparam logic [1:0] Coin2    = 2'b10;
    localparam logic [1:0] Coin5    = 2'b11;

    localparam logic [CREDIT_W-1:0] Val1 = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] Val2 = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] Val5 = CREDIT_W'(5);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StPresent,
        StDone,
        StJam
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] remaining_q, remaining_d;
    logic [STOCK_W-1:0]  stock1_q, stock1_d;
    logic [STOCK_W-1:0]  stock2_q, stock2_d;
    logic [STOCK_W-1:0]  stock5_q, stock5_d;
    logic [1:0]          sel_q, sel_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [1:0]          coin_out_q, coin_out_d;
    logic                coin_valid_q, coin_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                shortfall_q, shortfall_d;
    logic [CREDIT_W-1:0] short_amt_q, short_amt_d;
    logic                jam_q, jam_d;
    logic [CREDIT_W-1:0] coin_val;

    always_comb begin
        unique case (sel_q)
            Coin5:   coin_val = Val5;
            Coin2:   coin_val = Val2;
            Coin1:   coin_val = Val1;
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        stock1_d    = stock1_q;
        stock2_d    = stock2_q;
        stock5_d    = stock5_q;
        sel_d       = sel_q;
        tmr_d       = tmr_q;
        shortfall_d = shortfall_q;
        short_amt_d = short_amt_q;

        case (state_q)
            StIdle: begin
                if (stock_load) begin
                    stock1_d = stock1_in;
                    stock2_d = stock2_in;
                    stock5_d = stock5_in;
                end
                if (refund_req) begin
                    remaining_d = refund_amt;
                    shortfall_d = 1'b0;
                    short_amt_d = '0;
                    state_d     = (refund_amt == '0) ? StDone : StSelect;
                end
            end
            StSelect: begin
                tmr_d = '0;
                if (remaining_q >= Val5 && stock5_q != '0) begin
                    sel_d   = Coin5;
                    state_d = StPresent;
                end else if (remaining_q >= Val2 && stock2_q != '0) begin
                    sel_d   = Coin2;
                    state_d = StPresent;
                end else if (remaining_q >= Val1 && stock1_q != '0) begin
                    sel_d   = Coin1;
                    state_d = StPresent;
                end else begin
                    shortfall_d = 1'b1;
                    short_amt_d = remaining_q;
                    state_d     = StDone;
                end
            end
            StPresent: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - coin_val;
                    unique case (sel_q)
                        Coin5:   stock5_d = stock5_q - 1'b1;
                        Coin2:   stock2_d = stock2_q - 1'b1;
                        Coin1:   stock1_d = stock1_q - 1'b1;
                        default: ;
                    endcase
                    state_d = (remaining_d == '0) ? StDone : StSelect;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                    if (tmr_d == TMR_W'(TIMEOUT)) begin
                        state_d = StJam;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StJam:   state_d = StJam;
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies decoded from the upcoming state.
        coin_valid_d = (state_d == StPresent);
        coin_out_d   = coin_valid_d ? sel_d : CoinNone;
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
        jam_d        = (state_d == StJam);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            stock1_q     <= '0;
            stock2_q     <= '0;
            stock5_q     <= '0;
            sel_q        <= CoinNone;
            tmr_q        <= '0;
            coin_out_q   <= CoinNone;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            shortfall_q  <= 1'b0;
            short_amt_q  <= '0;
            jam_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            stock1_q     <= stock1_d;
            stock2_q     <= stock2_d;
            stock5_q     <= stock5_d;
            sel_q        <= sel_d;
            tmr_q        <= tmr_d;
            coin_out_q   <= coin_out_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            shortfall_q  <= shortfall_d;
            short_amt_q  <= short_amt_d;
            jam_q        <= jam_d;
        end
    end

    assign coin_out   = coin_out_q;
    assign coin_valid = coin_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign shortfall  = shortfall_q;
    assign short_amt  = short_amt_q;
    assign jam        = jam_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Cycle-by-cycle vector table for the change dispenser plus a hand-written jam sequence.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic       refund_req;
    logic [3:0] refund_amt;
    logic       stock_load;
    logic [3:0] stock1_in, stock2_in, stock5_in;
    logic       coin_ack;
    logic [1:0] coin_out;
    logic       coin_valid, busy, done, shortfall, jam;
    logic [3:0] short_amt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    change_dispenser #(
        .CREDIT_W(4),
        .STOCK_W (4),
        .TIMEOUT (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .refund_req(refund_req),
        .refund_amt(refund_amt),
        .stock_load(stock_load),
        .stock1_in (stock1_in),
        .stock2_in (stock2_in),
        .stock5_in (stock5_in),
        .coin_ack  (coin_ack),
        .coin_out  (coin_out),
        .coin_valid(coin_valid),
        .busy      (busy),
        .done      (done),
        .shortfall (shortfall),
        .short_amt (short_amt),
        .jam       (jam)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [3:0]  amt;
        logic        load;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  s5;
        logic        ack;
        logic [10:0] exp;  // {coin_out, coin_valid, busy, done, shortfall, short_amt, jam}
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input int rst, input int req, input int amt, input int load,
                               input int s1, input int s2, input int s5, input int ack,
                               input int coin, input int vld, input int bsy, input int dn,
                               input int sf, input int sh, input int jm);
        vec_t r;
        r.rst  = 1'(rst);
        r.req  = 1'(req);
        r.amt  = 4'(amt);
        r.load = 1'(load);
        r.s1   = 4'(s1);
        r.s2   = 4'(s2);
        r.s5   = 4'(s5);
        r.ack  = 1'(ack);
        r.exp  = {2'(coin), 1'(vld), 1'(bsy), 1'(dn), 1'(sf), 4'(sh), 1'(jm)};
        return r;
    endfunction

    function automatic logic [10:0] outs();
        return {coin_out, coin_valid, busy, done, shortfall, short_amt, jam};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b (coin,vld,busy,done,sf,short,jam)",
                     name, outs(), exp);
        end
    endtask

    task automatic drive(input vec_t r);
        reset      = r.rst;
        refund_req = r.req;
        refund_amt = r.amt;
        stock_load = r.load;
        stock1_in  = r.s1;
        stock2_in  = r.s2;
        stock5_in  = r.s5;
        coin_ack   = r.ack;
    endtask

    task automatic idle_inputs();
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b1;

        //        rst req amt ld s1 s2 s5 ack | coin vld bsy dn sf sh jam
        vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        // Stock 5/5/5, refund 8 -> 11, 10, 01
        vq.push_back(v(0, 1, 8, 1, 5, 5, 5, 0,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   2, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 1, 15, 1, 0, 0, 0, 0,  2, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        // Stock 2/1/0, refund 4 -> 10, 01, 01, then stock is empty
        vq.push_back(v(0, 1, 4, 1, 2, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 1, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0));
        // Stock1=1 only, refund 3 -> one coin then shortfall of 2
        vq.push_back(v(0, 1, 3, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 2, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 2, 0));
        // Zero refund: done next cycle, clears shortfall, busy for one cycle
        vq.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        // Reset during PRESENT wipes stock
        vq.push_back(v(0, 1, 5, 1, 3, 3, 3, 0,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vq.push_back(v(0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 1, 0));
        vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0));

        foreach (vq[i]) begin
            drive(vq[i]);
            tick();
            check($sformatf("vec%0d", i), vq[i].exp);
        end

        // No ack ever: 15 cycles of coin_valid, then jam
        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(v(0, 1, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        idle_inputs();
        tick();
        n = 0;
        while (coin_valid && n < 40) begin
            if (coin_out !== 2'b11) begin
                checks++;
                errors++;
                $display("FAIL jam_coin: got %b, want 11", coin_out);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL timeout_len: got %0d present cycles, want 15", n);
        end
        check("jam_set", {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1});
        drive(v(0, 1, 0, 1, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        tick();
        check("jam_ignores", {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1});
        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("jam_reset", 11'd0);
        idle_inputs();
        tick();
        check("post_reset_idle", 11'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
